// File: rtl/chip8_sprite_draw.sv
// chip8_sprite_draw
//   Executes the CHIP-8 DXYN sprite draw. It fetches N sprite bytes starting
//   at I and XORs each set bit into a 1-bit framebuffer at (VX+col, VY+row),
//   wrapping at the screen edges. VF (collision) is set when any lit pixel
//   is turned off.
//
// Ports
//   clk, reset       clock; synchronous active-low reset
//   start            one-cycle draw request; ignored while busy
//   vx, vy           sprite origin (taken modulo FB_W / FB_H)
//   i_reg, n         sprite base address and height in rows
//   mem_addr         sprite memory address; mem_rdata is returned one cycle later
//   fb_x, fb_y       framebuffer pixel address; fb_rdata is returned one cycle later
//   fb_wdata, fb_we  pixel write value and write strobe
//   busy, done       draw in progress / one-cycle completion pulse
//   collision        VF of the last completed draw
module chip8_sprite_draw #(
  parameter int FB_W = 64,
  parameter int FB_H = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              vx,
  input  logic [7:0]              vy,
  input  logic [11:0]             i_reg,
  input  logic [3:0]              n,
  output logic [11:0]             mem_addr,
  input  logic [7:0]              mem_rdata,
  output logic [$clog2(FB_W)-1:0] fb_x,
  output logic [$clog2(FB_H)-1:0] fb_y,
  input  logic                    fb_rdata,
  output logic                    fb_wdata,
  output logic                    fb_we,
  output logic                    busy,
  output logic                    done,
  output logic                    collision
);

  localparam int XW = $clog2(FB_W);
  localparam int YW = $clog2(FB_H);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_PIX   = 3'd3;
  localparam logic [2:0] S_XORW  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [XW-1:0] x0_q, x0_d;
  logic [YW-1:0] y0_q, y0_d;
  logic [11:0]   i_q, i_d;
  logic [3:0]    n_q, n_d;
  logic [3:0]    row_q, row_d;
  logic [2:0]    col_q, col_d;
  logic [7:0]    byte_q, byte_d;
  logic          acc_q, acc_d;
  logic          collision_q, collision_d;

  // Wrapped pixel coordinate of the current column/row; the additions are
  // sized to the framebuffer so they wrap naturally.
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          cur_bit;
  logic [3:0]    row_inc;

  assign pix_x   = x0_q + XW'(col_q);
  assign pix_y   = y0_q + YW'(row_q);
  assign cur_bit = byte_q[3'd7 - col_q];
  assign row_inc = row_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    i_d         = i_q;
    n_d         = n_q;
    row_d       = row_q;
    col_d       = col_q;
    byte_d      = byte_q;
    acc_d       = acc_q;
    collision_d = collision_q;

    mem_addr = 12'd0;
    fb_x     = '0;
    fb_y     = '0;
    fb_wdata = 1'b0;
    fb_we    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x0_d    = XW'(vx);
          y0_d    = YW'(vy);
          i_d     = i_reg;
          n_d     = n;
          row_d   = 4'd0;
          col_d   = 3'd0;
          acc_d   = 1'b0;
          state_d = (n == 4'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        mem_addr = i_q + 12'(row_q);  // 12-bit sum wraps at 4096
        state_d  = S_LATCH;
      end
      S_LATCH: begin
        byte_d  = mem_rdata;
        col_d   = 3'd0;
        state_d = S_PIX;
      end
      S_PIX, S_XORW: begin
        // A PIX cycle with a set bit only issues the read; the column
        // advances once the pixel has been written back in XORW.
        if (state_q == S_PIX && cur_bit) begin
          fb_x    = pix_x;
          fb_y    = pix_y;
          state_d = S_XORW;
        end else begin
          if (state_q == S_XORW) begin
            fb_x     = pix_x;
            fb_y     = pix_y;
            fb_we    = 1'b1;
            fb_wdata = ~fb_rdata;
            acc_d    = acc_q | fb_rdata;
          end
          if (col_q != 3'd7) begin
            col_d   = col_q + 3'd1;
            state_d = S_PIX;
          end else begin
            row_d   = row_inc;
            state_d = (row_inc == n_q) ? S_DONE : S_FETCH;
          end
        end
      end
      S_DONE: begin
        collision_d = acc_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      i_q         <= 12'd0;
      n_q         <= 4'd0;
      row_q       <= 4'd0;
      col_q       <= 3'd0;
      byte_q      <= 8'd0;
      acc_q       <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      i_q         <= i_d;
      n_q         <= n_d;
      row_q       <= row_d;
      col_q       <= col_d;
      byte_q      <= byte_d;
      acc_q       <= acc_d;
      collision_q <= collision_d;
    end
  end

  // busy stays high through DONE so a start in that cycle is ignored.
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign collision = collision_q;

endmodule

// File: tb/tb_chip8_sprite_draw.sv
module tb_chip8_sprite_draw;
  localparam int FB_W = 64;
  localparam int FB_H = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  vx, vy;
  logic [11:0] i_reg;
  logic [3:0]  n;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [5:0]  fb_x;
  logic [4:0]  fb_y;
  logic        fb_rdata;
  logic        fb_wdata, fb_we, busy, done, collision;

  chip8_sprite_draw #(.FB_W(FB_W), .FB_H(FB_H)) dut (
    .clk(clk), .reset(reset), .start(start), .vx(vx), .vy(vy),
    .i_reg(i_reg), .n(n), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .fb_x(fb_x), .fb_y(fb_y), .fb_rdata(fb_rdata), .fb_wdata(fb_wdata),
    .fb_we(fb_we), .busy(busy), .done(done), .collision(collision)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Behavioural sprite memory and framebuffer, both with one-cycle read latency.
  logic [7:0] smem [0:4095];
  logic       fbm  [0:FB_W*FB_H-1];
  always @(posedge clk) begin
    mem_rdata <= smem[mem_addr];
    fb_rdata  <= fbm[{fb_y, fb_x}];
    if (fb_we) fbm[{fb_y, fb_x}] <= fb_wdata;
  end

  typedef struct { int x; int y; int w; } wr_t;
  typedef struct { int sc; int lat; int coll; } dn_t;
  wr_t wr_q[$];
  dn_t dn_q[$];

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  bit coll_pending = 0;
  int coll_exp = 0;

  // Monitor: pops expectations whenever the DUT writes a pixel or signals done.
  always @(negedge clk) begin
    wr_t w;
    dn_t d;
    if (coll_pending) begin
      checks++;
      if (collision !== coll_exp[0]) begin
        errors++;
        $display("FAIL collision got %0b exp %0d", collision, coll_exp);
      end
      coll_pending = 0;
    end
    if (fb_we === 1'b1) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got (%0d,%0d,%0b) exp none", fb_x, fb_y, fb_wdata);
      end else begin
        w = wr_q.pop_front();
        if (fb_x != w.x[5:0] || fb_y != w.y[4:0] || fb_wdata !== w.w[0]) begin
          errors++;
          $display("FAIL write got (%0d,%0d,%0b) exp (%0d,%0d,%0d)",
                   fb_x, fb_y, fb_wdata, w.x, w.y, w.w);
        end else
          $display("write (%0d,%0d) <= %0b", fb_x, fb_y, fb_wdata);
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      checks++;
      if (dn_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done got done=1 at cycle %0d exp none", cyc);
      end else begin
        d = dn_q.pop_front();
        if (cyc - d.sc != d.lat) begin
          errors++;
          $display("FAIL latency got %0d exp %0d", cyc - d.sc, d.lat);
        end else
          $display("done latency %0d", cyc - d.sc);
        coll_exp = d.coll;
        coll_pending = 1;
      end
    end
    if (busy === 1'b0) begin
      checks++;
      if (mem_addr != 12'd0 || fb_x != 6'd0 || fb_y != 5'd0 || fb_we !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs got addr=%0h x=%0d y=%0d we=%0b exp 0",
                 mem_addr, fb_x, fb_y, fb_we);
      end
    end
  end

  task automatic push_wr(input int x, input int y, input int w);
    wr_t e;
    e.x = x; e.y = y; e.w = w;
    wr_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic draw(input int ax, input int ay, input int ai, input int an,
                      input int lat, input int coll);
    dn_t e;
    int target;
    tick();
    e.sc = cyc; e.lat = lat; e.coll = coll;
    dn_q.push_back(e);
    target = done_cnt + 1;
    vx = 8'(ax); vy = 8'(ay); i_reg = 12'(ai); n = 4'(an);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 200 && done_cnt < target; k++) tick();
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL done_timeout got no done exp done within 200 cycles");
    end
    tick();
    tick();
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || fb_we !== 1'b0 || collision !== 1'b0 ||
        mem_addr != 12'd0 || fb_x != 6'd0 || fb_y != 5'd0 || fb_wdata !== 1'b0) begin
      errors++;
      $display("FAIL %s got busy=%0b done=%0b we=%0b coll=%0b addr=%0h x=%0d y=%0d wd=%0b exp all 0",
               tag, busy, done, fb_we, collision, mem_addr, fb_x, fb_y, fb_wdata);
    end else
      $display("%s outputs all zero", tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 4096; k++) smem[k] = 8'h00;
    for (int k = 0; k < FB_W*FB_H; k++) fbm[k] = 1'b0;
    smem[12'h010] = 8'hFF;
    smem[12'h020] = 8'hC0;
    smem[12'h021] = 8'h80;
    smem[12'hFFF] = 8'h01;
    smem[12'h000] = 8'h80;

    reset = 1'b0; start = 1'b0; vx = 0; vy = 0; i_reg = 0; n = 0;
    repeat (3) tick();
    check_reset_state("reset_state");
    reset = 1'b1;
    tick();

    // Full-width row on a blank screen.
    for (int k = 0; k < 8; k++) push_wr(k, 0, 1);
    draw(0, 0, 12'h010, 1, 19, 0);

    // Same draw again erases every pixel and flags a collision.
    for (int k = 0; k < 8; k++) push_wr(k, 0, 0);
    draw(0, 0, 12'h010, 1, 19, 1);

    // Busy start ignored, start under reset ignored, reset aborts mid-row.
    // Draw begins in cycle 0: XORW for columns 0 and 1 falls in cycles 4 and 6;
    // reset is low during cycle 6 and takes effect at the end of it.
    push_wr(0, 0, 1);
    push_wr(1, 0, 1);
    tick();
    vx = 0; vy = 0; i_reg = 12'h010; n = 4'd1; start = 1'b1;   // cycle 0
    tick(); start = 1'b0;                                       // cycle 1
    tick();                                                     // cycle 2
    tick(); vx = 8'd5; n = 4'd3; start = 1'b1;                  // cycle 3 (busy)
    tick(); start = 1'b0;                                       // cycle 4
    tick();                                                     // cycle 5
    tick(); reset = 1'b0; start = 1'b1;                         // cycle 6
    tick(); reset = 1'b1; start = 1'b0;
    check_reset_state("abort_state");
    repeat (30) tick();
    checks++;
    if (busy !== 1'b0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL after_abort got busy=%0b pending_writes=%0d exp busy=0 pending=0",
               busy, wr_q.size());
    end else
      $display("after_abort idle, no further writes");

    // Wrap in both axes.
    push_wr(62, 31, 1);
    push_wr(63, 31, 1);
    push_wr(62, 0, 1);
    draw(62, 31, 12'h020, 2, 24, 0);

    // n=0 with start held into the DONE cycle: exactly one done.
    tick();
    begin
      dn_t e;
      e.sc = cyc; e.lat = 1; e.coll = 0;
      dn_q.push_back(e);
    end
    vx = 0; vy = 0; i_reg = 12'h010; n = 4'd0; start = 1'b1;
    tick();
    tick(); start = 1'b0;
    repeat (10) tick();
    checks++;
    if (dn_q.size() != 0) begin
      errors++;
      $display("FAIL n0_done got pending=%0d exp 0", dn_q.size());
    end

    // Address wrap: second fetch must read address 0x000.
    push_wr(17, 5, 1);
    push_wr(10, 6, 1);
    draw(10, 5, 12'hFFF, 2, 23, 0);

    repeat (5) tick();
    checks++;
    if (wr_q.size() != 0 || dn_q.size() != 0) begin
      errors++;
      $display("FAIL leftover got writes=%0d dones=%0d exp 0 0", wr_q.size(), dn_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/chip8_sprite_draw.md
CHIP8_SPRITE_DRAW -- requirements
Module: chip8_sprite_draw

Interface
REQ-001 Parameter FB_W, 64, framebuffer width in pixels; power of two.
REQ-002 Parameter FB_H, 32, framebuffer height in pixels; power of two.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 reset  in  1  synchronous, active-low reset; sampled on posedge clk.
REQ-005 start  in  1  one-cycle DXYN draw request.
REQ-006 vx, vy  in  8 each  sprite origin from registers VX, VY.
REQ-007 i_reg  in  12  sprite base address (I).
REQ-008 n  in  4  sprite height in rows.
REQ-009 mem_addr  out  12  sprite memory read address.
REQ-010 mem_rdata  in  8  memory data, valid one cycle after mem_addr.
REQ-011 fb_x / fb_y  out  log2(FB_W) / log2(FB_H)  framebuffer pixel address.
REQ-012 fb_rdata  in  1  pixel value, valid one cycle after fb_x/fb_y.
REQ-013 fb_wdata  out  1  pixel write value.
REQ-014 fb_we  out  1  pixel write strobe.
REQ-015 busy  out  1  high while a draw is in progress.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 collision  out  1  VF result of the last completed draw.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, LATCH, PIX, XORW and DONE.
REQ-019 In IDLE with start=1, the block SHALL latch vx mod FB_W, vy mod FB_H, i_reg and n, clear row, col and the collision accumulator, and assert busy from the next cycle.
REQ-020 From IDLE on start, the FSM SHALL go to DONE if n=0, else to FETCH.
REQ-021 FETCH SHALL drive mem_addr = (i + row) mod 4096 and go to LATCH.
REQ-022 LATCH SHALL capture mem_rdata into the sprite byte, set col=0 and go to PIX.
REQ-023 PIX with byte bit (7-col)=1 SHALL drive fb_x=(x0+col) mod FB_W, fb_y=(y0+row) mod FB_H and go to XORW.
REQ-024 PIX with that bit=0 SHALL advance the column with no framebuffer access.
REQ-025 XORW SHALL hold the same fb_x/fb_y, assert fb_we=1 with fb_wdata=~fb_rdata, OR fb_rdata into the accumulator, then advance the column.
REQ-026 Column advance SHALL be: if col<7, col+1 and go to PIX; else row+1, then DONE if row+1=n, else FETCH.
REQ-027 Pixel coordinates SHALL wrap modulo FB_W/FB_H; there is no clipping.
REQ-028 DONE SHALL assert done=1 for exactly one cycle, load collision from the accumulator, deassert busy and return to IDLE.
REQ-029 Latency SHALL be: done asserted exactly 1 + sum over rows of (10 + set bits in row) cycles after the start cycle; n=0 gives 1.
REQ-030 fb_we SHALL be high only in XORW, for exactly one cycle per set sprite bit.
REQ-031 start SHALL be ignored while busy=1, including in the DONE cycle.
REQ-032 collision SHALL hold its value until the next DONE.
REQ-033 mem_addr, fb_x and fb_y SHALL be 0 when not actively addressing.

Reset
REQ-034 On reset=0 at a clock edge, the state SHALL go to IDLE and busy, done, fb_we, collision, mem_addr, fb_x, fb_y and fb_wdata SHALL all be 0.
REQ-035 Reset mid-draw SHALL abort immediately with no further fb_we; partially written pixels remain.
REQ-036 start received while reset=0 SHALL be ignored.

Verification
REQ-037 Blank FB, vx=0, vy=0, n=1, mem[i]=0xFF: done 19 cycles after start, 8 writes at x=0..7, y=0 with wdata=1, collision=0.
REQ-038 Repeat the same draw: all 8 pixels are cleared to 0, collision=1.
REQ-039 vx=62, vy=31, n=2, bytes 0xC0, 0x80: writes at (62,31), (63,31) and (62,0), exercising wrap; done after 1+12+11=24 cycles.
REQ-040 n=0: done 1 cycle after start, no fb_we, collision=0.
REQ-041 i_reg=0xFFF, n=2: second fetch uses mem_addr=0x000.
REQ-042 Pulse start during busy, and drop reset for one cycle mid-row: the second start is ignored; after reset, busy=0, collision=0 and no writes occur.
